// File: rtl/mem_arb_pkg.sv
// Shared types and requester IDs for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      SZ_NONE = 2'd0,
      SZ_BYTE = 2'd1,
      SZ_HALF = 2'd2,
      SZ_WORD = 2'd3
   } mem_size_t;

   localparam logic [1:0] REQ_CRD = 2'd0;
   localparam logic [1:0] REQ_CWR = 2'd1;
   localparam logic [1:0] REQ_X   = 2'd2;
   localparam int         NREQ    = 3;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_WAIT = 1'b1
   } arb_state_t;

   // Requester after id in the rotation c_rd -> c_wr -> x -> c_rd.
   function automatic logic [1:0] next_id(input logic [1:0] id);
      return (id == REQ_X) ? REQ_CRD : id + 2'd1;
   endfunction

endpackage

// File: rtl/arb_pick3.sv
// Three-way winner picker: fixed priority x > c_wr > c_rd, or round-robin
// with a registered pointer when ARB_RR_EN is defined.
module arb_pick3
   import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
   input  logic       clk,
   input  logic       reset,
   input  logic       i_adv,
`endif
   input  logic [2:0] i_pend,
   output logic [1:0] o_win
);

`ifdef ARB_RR_EN
   logic [1:0] r_ptr;
   logic [1:0] w_c1;
   logic [1:0] w_c2;

   // Pointer moves to the requester just after the one granted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_ptr <= REQ_CRD;
      else if (i_adv)
         r_ptr <= next_id(o_win);
   end

   always_comb begin
      w_c1  = next_id(r_ptr);
      w_c2  = next_id(w_c1);
      o_win = r_ptr;
      if (i_pend[r_ptr])
         o_win = r_ptr;
      else if (i_pend[w_c1])
         o_win = w_c1;
      else if (i_pend[w_c2])
         o_win = w_c2;
   end
`else
   always_comb begin
      if (i_pend[REQ_X])
         o_win = REQ_X;
      else if (i_pend[REQ_CWR])
         o_win = REQ_CWR;
      else
         o_win = REQ_CRD;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU read, CPU write and external master pulses onto one
// held-request/ack memory bus. Define ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    c_rd_sig,
   input  logic [AW-1:0] c_rd_addr,
   output logic          c_rd_ready,
   output logic [DW-1:0] c_rd_data,
   input  logic [1:0]    c_wr_sig,
   input  logic [AW-1:0] c_wr_addr,
   input  logic [DW-1:0] c_wr_data,
   output logic          c_wr_ready,
   input  logic [1:0]    x_sig,
   input  logic          x_we,
   input  logic [AW-1:0] x_addr,
   input  logic [DW-1:0] x_wdata,
   output logic          x_ready,
   output logic [DW-1:0] x_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [1:0]    mem_size,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          overrun
);

   arb_state_t    r_state;
   arb_state_t    w_state_nx;
   logic          w_load;
   logic          w_done;

   logic [2:0]    r_pend;
   logic [AW-1:0] r_addr  [NREQ];
   logic [1:0]    r_size  [NREQ];
   logic          r_we    [NREQ];
   logic [DW-1:0] r_wdata [NREQ];
   logic [1:0]    r_win;

   logic [1:0]    w_in_sig   [NREQ];
   logic [AW-1:0] w_in_addr  [NREQ];
   logic          w_in_we    [NREQ];
   logic [DW-1:0] w_in_wdata [NREQ];
   logic [2:0]    w_req;
   logic [2:0]    w_cap;
   logic [2:0]    w_eff;
   logic          w_drop;
   logic [1:0]    w_pick;

   logic          r_mem_req;
   logic          r_mem_we;
   logic [1:0]    r_mem_size;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          w_sel_we;
   logic [1:0]    w_sel_size;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;

   logic          r_c_rd_ready;
   logic          r_c_wr_ready;
   logic          r_x_ready;
   logic [DW-1:0] r_c_rd_data;
   logic [DW-1:0] r_x_rdata;
   logic          r_overrun;

   // Write data is zeroed at capture for reads so mem_wdata is 0 on reads.
   always_comb begin
      w_in_sig[REQ_CRD]   = c_rd_sig;
      w_in_addr[REQ_CRD]  = c_rd_addr;
      w_in_we[REQ_CRD]    = 1'b0;
      w_in_wdata[REQ_CRD] = '0;
      w_in_sig[REQ_CWR]   = c_wr_sig;
      w_in_addr[REQ_CWR]  = c_wr_addr;
      w_in_we[REQ_CWR]    = 1'b1;
      w_in_wdata[REQ_CWR] = c_wr_data;
      w_in_sig[REQ_X]     = x_sig;
      w_in_addr[REQ_X]    = x_addr;
      w_in_we[REQ_X]      = x_we;
      w_in_wdata[REQ_X]   = x_we ? x_wdata : '0;
      for (int i = 0; i < NREQ; i++) begin
         w_req[i] = (w_in_sig[i] != SZ_NONE);
         w_cap[i] = w_req[i] & ~r_pend[i];
      end
      w_drop = |(w_req & r_pend);
      w_eff  = r_pend | w_cap;
   end

   arb_pick3 u_pick (
`ifdef ARB_RR_EN
      .clk    (clk),
      .reset  (reset),
      .i_adv  (w_load),
`endif
      .i_pend (w_eff),
      .o_win  (w_pick)
   );

   // A winner captured this very cycle has not reached its slot yet.
   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_size  = SZ_NONE;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick == 2'(i)) begin
            w_sel_we    = w_cap[i] ? w_in_we[i]    : r_we[i];
            w_sel_size  = w_cap[i] ? w_in_sig[i]   : r_size[i];
            w_sel_addr  = w_cap[i] ? w_in_addr[i]  : r_addr[i];
            w_sel_wdata = w_cap[i] ? w_in_wdata[i] : r_wdata[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ARB_IDLE;
      else
         r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_load     = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (|w_eff) begin
               w_load     = 1'b1;
               w_state_nx = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (mem_ack) begin
               w_done     = 1'b1;
               w_state_nx = ARB_IDLE;
            end
         end
         default: w_state_nx = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend       <= '0;
         r_win        <= REQ_CRD;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_size   <= SZ_NONE;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_c_rd_ready <= 1'b0;
         r_c_wr_ready <= 1'b0;
         r_x_ready    <= 1'b0;
         r_c_rd_data  <= '0;
         r_x_rdata    <= '0;
         r_overrun    <= 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            r_addr[i]  <= '0;
            r_size[i]  <= SZ_NONE;
            r_we[i]    <= 1'b0;
            r_wdata[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            r_pend[i] <= (r_pend[i] & ~(w_done && r_win == 2'(i))) | w_cap[i];
            if (w_cap[i]) begin
               r_addr[i]  <= w_in_addr[i];
               r_size[i]  <= w_in_sig[i];
               r_we[i]    <= w_in_we[i];
               r_wdata[i] <= w_in_wdata[i];
            end
         end
         if (w_drop)
            r_overrun <= 1'b1;
         if (w_load) begin
            r_win       <= w_pick;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_size  <= w_sel_size;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
         end else if (w_done) begin
            r_mem_req   <= 1'b0;
         end
         r_c_rd_ready <= w_done && (r_win == REQ_CRD);
         r_c_wr_ready <= w_done && (r_win == REQ_CWR);
         r_x_ready    <= w_done && (r_win == REQ_X);
         if (w_done && r_win == REQ_CRD)
            r_c_rd_data <= mem_rdata;
         if (w_done && r_win == REQ_X && !r_mem_we)
            r_x_rdata <= mem_rdata;
      end
   end

   assign c_rd_ready = r_c_rd_ready;
   assign c_rd_data  = r_c_rd_data;
   assign c_wr_ready = r_c_wr_ready;
   assign x_ready    = r_x_ready;
   assign x_rdata    = r_x_rdata;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_size   = r_mem_size;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign overrun    = r_overrun;

endmodule
